// File: rtl/add_sub_pkg.sv
// Shared constants, types and helpers for the pipelined add/sub datapath.
package add_sub_pkg;

    localparam int unsigned MAX_STAGES = 8;
    localparam int unsigned MIN_SEG    = 8;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } add_flags_t;

    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/add_sub_seg.sv
// One carry segment of the pipelined adder: SEG-bit add at bit LSB, with the operands,
// partial sum and running zero flag registered alongside for the following stages.
module add_sub_seg #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEG   = 16,
    parameter int unsigned LSB   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic             zero_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o
);

    logic [SEG:0]     seg_add;
    logic [WIDTH-1:0] sum_d;

    logic             valid_q, carry_q, zero_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;

    always_comb begin
        seg_add = {1'b0, a_i[LSB +: SEG]} + {1'b0, b_i[LSB +: SEG]} + {{SEG{1'b0}}, carry_i};
        sum_d   = sum_i;
        sum_d[LSB +: SEG] = seg_add[SEG-1:0];
    end

    // Data only loads on a real beat so bubbles leave the last result visible downstream.
    // Operand bits already consumed are dead past this stage and prune away in synthesis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            if (en_i) begin
                valid_q <= valid_i;
            end
            if (en_i && valid_i) begin
                carry_q <= seg_add[SEG];
                zero_q  <= zero_i & ~|seg_add[SEG-1:0];
                a_q     <= a_i;
                b_q     <= b_i;
                sum_q   <= sum_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract split into STAGES registered carry segments with valid/ready flow.
// Define ADD_SUB_SATURATE_EN to clamp overflowing results to the signed extreme.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_add_sub_if.slave bus
);

    localparam int unsigned SEG = seg_width(WIDTH, STAGES);

    logic             adv;
    logic [STAGES:0]  valid_s, carry_s, zero_s;
    logic [WIDTH-1:0] a_s   [STAGES+1];
    logic [WIDTH-1:0] b_s   [STAGES+1];
    logic [WIDTH-1:0] sum_s [STAGES+1];

    // Single global enable: the whole pipe stalls only when a result is waiting unclaimed.
    assign adv          = !valid_s[STAGES] || bus.out_ready;
    assign bus.in_ready = adv;

    assign valid_s[0] = bus.in_valid;
    assign carry_s[0] = bus.sub | bus.cin;
    assign zero_s[0]  = 1'b1;
    assign a_s[0]     = bus.a;
    assign b_s[0]     = bus.sub ? ~bus.b : bus.b;
    assign sum_s[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_sub_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .LSB   (k * SEG)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv),
            .valid_i (valid_s[k]),
            .carry_i (carry_s[k]),
            .zero_i  (zero_s[k]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .valid_o (valid_s[k+1]),
            .carry_o (carry_s[k+1]),
            .zero_o  (zero_s[k+1]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1])
        );
    end

    logic             a_msb, b_msb;
    logic [WIDTH-1:0] sum_wrap, sum_out;
    add_flags_t       flags;

    always_comb begin
        a_msb      = a_s[STAGES][WIDTH-1];
        b_msb      = b_s[STAGES][WIDTH-1];
        sum_wrap   = sum_s[STAGES];
        flags.cout = carry_s[STAGES];
        flags.ovf  = (a_msb == b_msb) && (sum_wrap[WIDTH-1] != a_msb);
`ifdef ADD_SUB_SATURATE_EN
        // A clamped result is never zero, so ZERO only survives without overflow.
        sum_out    = flags.ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : sum_wrap;
        flags.zero = zero_s[STAGES] & ~flags.ovf;
`else
        sum_out    = sum_wrap;
        flags.zero = zero_s[STAGES];
`endif
    end

    assign bus.out_valid = valid_s[STAGES];
    assign bus.sum       = sum_out;
    assign bus.cout      = flags.cout;
    assign bus.ovf       = flags.ovf;
    assign bus.zero      = flags.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: vector table, back-pressure, mid-flight reset
// and small-width parameter sweeps, all checked through expected-result queues.
module tb_pipelined_add_sub;

`ifdef ADD_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] sum;
        logic        cout, ovf, zero;
        int          t;
    } exp_t;

    typedef struct {
        logic [63:0] a, b;
        logic        cin, sub;
        logic [63:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(64)) bus   ();
    pipelined_add_sub_if #(.WIDTH(32)) bus32 ();
    pipelined_add_sub_if #(.WIDTH(16)) bus16 ();

    pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pipelined_add_sub #(.WIDTH(16), .STAGES(2)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out64 = 0;
    int   n_out32 = 0;
    bit   lat_on = 1'b0;
    exp_t q64[$], q32[$], q16[$];
    exp_t drv64, drv32, drv16;
    vec_t tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [63:0] a_in, b_in, input logic cin,
                                   input logic sub, input int w);
        exp_t        e;
        logic [63:0] mask, a, be, s;
        logic [64:0] full;
        logic        amsb, bmsb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        be   = (sub ? ~b_in : b_in) & mask;
        full = {1'b0, a} + {1'b0, be} + {64'd0, (sub | cin)};
        s    = full[63:0] & mask;
        amsb = a[w-1];
        bmsb = be[w-1];
        e.cout = full[w];
        e.ovf  = (amsb == bmsb) && (s[w-1] != amsb);
        if (SAT && e.ovf) s = amsb ? (64'd1 << (w - 1)) : (mask >> 1);
        e.sum  = s;
        e.zero = (s == 64'd0);
        e.t    = 0;
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] a, b, input logic cin, sub,
                                input logic [63:0] sum, input logic cout, ovf, zero);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string name, inout exp_t q[$], input logic [63:0] sum,
                           input logic cout, ovf, zero, input bit lat, input int stages);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_out: got sum=%h with no beat outstanding", name, sum);
        end else begin
            e = q.pop_front();
            chk({name, "_sum"}, sum, e.sum);
            chk({name, "_flags"}, {61'd0, cout, ovf, zero}, {61'd0, e.cout, e.ovf, e.zero});
            if (lat) chk({name, "_latency"}, 64'(cyc - e.t), 64'(stages));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (bus.in_valid && bus.in_ready) begin
                e = drv64; e.t = cyc; q64.push_back(e);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out64++;
                pop_cmp("w64", q64, bus.sum, bus.cout, bus.ovf, bus.zero, lat_on, 4);
            end
            if (bus32.in_valid && bus32.in_ready) begin
                e = drv32; e.t = cyc; q32.push_back(e);
            end
            if (bus32.out_valid && bus32.out_ready) begin
                n_out32++;
                pop_cmp("w32", q32, 64'(bus32.sum), bus32.cout, bus32.ovf, bus32.zero, 1'b1, 1);
            end
            if (bus16.in_valid && bus16.in_ready) begin
                e = drv16; e.t = cyc; q16.push_back(e);
            end
            if (bus16.out_valid && bus16.out_ready) begin
                pop_cmp("w16", q16, 64'(bus16.sum), bus16.cout, bus16.ovf, bus16.zero, 1'b1, 2);
            end
        end
    end

    task automatic send(input logic [63:0] a, b, input logic cin, sub, input exp_t e);
        int n = 0;
        bit ok = 1'b0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1;
        drv64 = e;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        bus.in_valid = 1'b0;
        if (!ok) chk("send_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q64.size() + q32.size() + q16.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(q64.size() + q32.size() + q16.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   base;
        tbl[0] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                    SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
        tbl[1] = mk(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        tbl[2] = mk(64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tbl[3] = mk(64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                    SAT ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[5] = mk(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        tbl[8] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                    SAT ? 64'h8000_0000_0000_0000 : 64'h0, 1'b1, 1'b1, !SAT);
        tbl[9] = mk(64'h7, 64'h7, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset state, both while held and once released
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", bus.sum, 64'd0);
        chk("rst_flags", {61'd0, bus.cout, bus.ovf, bus.zero}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // Vector table, back-to-back at full throughput
        lat_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf; e.zero = tbl[i].zero;
            e.t = 0;
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
        end
        drain();
        chk("table_out_count", 64'(n_out64), 64'd10);
        lat_on = 1'b0;

        // Back-pressure: OUT_READY low for relative cycles 3..8 while streaming 6 beats
        base = n_out64;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(64'(i), 64'(i), 1'b0, 1'b0,
                                                 model(64'(i), 64'(i), 1'b0, 1'b0, 64));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 3 && c <= 8);
                    @(negedge clk);
                    if (c >= 4 && c <= 8) begin
                        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                        chk("stall_sum_stable", bus.sum, 64'd2);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_out_count", 64'(n_out64 - base), 64'd6);

        // Reset mid-flight: three beats in the pipe are discarded
        for (int i = 0; i < 3; i++) send(64'h100 + 64'(i), 64'h1, 1'b0, 1'b0,
                                         model(64'h100 + 64'(i), 64'h1, 1'b0, 1'b0, 64));
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_sum", bus.sum, 64'd0);
        q64.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        base = n_out64;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(n_out64 - base), 64'd0);
        send(64'h1234, 64'h0234, 1'b0, 1'b1, model(64'h1234, 64'h0234, 1'b0, 1'b1, 64));
        drain();
        chk("midrst_fresh_count", 64'(n_out64 - base), 64'd1);

        // Parameter sweep: 32/1 and 16/2 with random operands every cycle
        for (int i = 0; i < 40; i++) begin
            bus32.a = $urandom; bus32.b = $urandom;
            bus32.cin = 1'($urandom); bus32.sub = 1'($urandom);
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
            if (i == 0) begin
                bus16.a = 16'h7FFF; bus16.b = 16'h0001; bus16.sub = 1'b0; bus16.cin = 1'b0;
            end
            drv32 = model(64'(bus32.a), 64'(bus32.b), bus32.cin, bus32.sub, 32);
            drv16 = model(64'(bus16.a), 64'(bus16.b), bus16.cin, bus16.sub, 16);
            bus32.in_valid = 1'b1;
            bus16.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus32.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
        drain();
        chk("sweep32_out_count", 64'(n_out32), 64'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
